cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/seq_prog_mem.sv | 34 +++
 rtl/cpu_sequencer.sv | 140 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, instruction word layout and sequencer state
//                encoding for the cpu_core program sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_AW    = 3;    // register-file address width of cpu_core
    localparam int c_DW    = 8;    // data width of cpu_core
    localparam int c_DEPTH = 16;   // program buffer entries (power of 2)

    // One cpu_core control word, packed MSB-first as presented on prog_instr
    typedef struct packed {
        logic [1:0]      alu_sel;
        logic            w_en;
        logic [c_AW-1:0] a1;
        logic [c_AW-1:0] a2;
        logic [c_DW-1:0] din;
        logic            din_sel;
        logic            d2_sel;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : seq_prog_mem
//  Description : Program storage, DEPTH x instr_t. One synchronous write port
//                for loading, one combinational read port for issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_prog_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  instr_t            wdata,
    input  logic [ADDR_W-1:0] raddr,
    output instr_t            rdata
);

    instr_t r_mem [DEPTH];

    // Store an accepted load word; contents are never cleared, only overwritten
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Loads a short program of cpu_core control words, then plays
//                it out one word per cycle, drains one cycle, captures the
//                core's dout and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int AW    = c_AW,
    parameter int DW    = c_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_valid,
    input  instr_t                   prog_instr,
    output logic                     prog_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     abort,
    output logic [1:0]               alu_sel,
    output logic                     w_en,
    output logic [AW-1:0]            a1,
    output logic [AW-1:0]            a2,
    output logic [DW-1:0]            din,
    output logic                     din_sel,
    output logic                     d2_sel,
    input  logic [DW-1:0]            core_dout,
    output logic                     busy,
    output logic                     done,
    output logic [DW-1:0]            result,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_IW = $clog2(DEPTH);       // buffer index width
    localparam int c_PW = $clog2(DEPTH) + 1;   // count/pc width, holds DEPTH itself
    localparam logic [c_PW-1:0] c_FULL = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_ONE  = c_PW'(1);

    state_t          r_state;
    logic [c_PW-1:0] r_count;
    logic [c_PW-1:0] r_pc;
    instr_t          r_ctrl;
    logic            r_done;
    logic [DW-1:0]   r_result;

    instr_t          w_mem_rd;
    logic            w_load;

    // Loading is only possible while idle and not simultaneously starting/clearing
    assign prog_ready = (r_state == IDLE) && (r_count < c_FULL) && !start && !clear;
    assign w_load     = prog_valid && prog_ready;

    seq_prog_mem #(
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (w_load),
        .waddr (r_count[c_IW-1:0]),
        .wdata (prog_instr),
        .raddr (r_pc[c_IW-1:0]),
        .rdata (w_mem_rd)
    );

    // Sequencer FSM: load/clear in IDLE, issue in RUN, one idle slot in DRAIN,
    // then capture the core result with a single-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_pc     <= '0;
            r_ctrl   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ctrl <= '0;
                    if (clear) begin
                        r_count <= '0;
                    end else if (start && (r_count != '0)) begin
                        r_state <= RUN;
                        r_pc    <= '0;
                    end else if (w_load) begin
                        r_count <= r_count + c_ONE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_ctrl  <= '0;
                    end else if (r_pc < r_count) begin
                        // pc is one bit wider than the index, so a full buffer never wraps
                        r_ctrl <= w_mem_rd;
                        r_pc   <= r_pc + c_ONE;
                    end else begin
                        r_state <= DRAIN;
                        r_ctrl  <= '0;
                    end
                end
                DRAIN: begin
                    r_ctrl <= '0;
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_state  <= CAPTURE;
                        r_result <= core_dout;
                        r_done   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_ctrl  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ctrl  <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_sel = r_ctrl.alu_sel;
    assign w_en    = r_ctrl.w_en;
    assign a1      = r_ctrl.a1;
    assign a2      = r_ctrl.a2;
    assign din     = r_ctrl.din;
    assign din_sel = r_ctrl.din_sel;
    assign d2_sel  = r_ctrl.d2_sel;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign result  = r_result;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer with a small behavioural
//                cpu_core attached to the control outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_valid = 1'b0;
    instr_t        prog_instr = '0;
    logic          prog_ready;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    alu_sel;
    logic          w_en;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] din;
    logic          din_sel;
    logic          d2_sel;
    logic [DW-1:0] core_dout = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_valid (prog_valid),
        .prog_instr (prog_instr),
        .prog_ready (prog_ready),
        .clear      (clear),
        .start      (start),
        .abort      (abort),
        .alu_sel    (alu_sel),
        .w_en       (w_en),
        .a1         (a1),
        .a2         (a2),
        .din        (din),
        .din_sel    (din_sel),
        .d2_sel     (d2_sel),
        .core_dout  (core_dout),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .count      (count)
    );

    // ---------------- behavioural cpu_core -----------------
    function automatic logic [DW-1:0] alu_f(input logic [1:0] sel, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
        case (sel)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x | y;
        endcase
    endfunction

    logic [DW-1:0] core_regs [8];
    wire  [DW-1:0] core_alu = alu_f(alu_sel, core_regs[a1], d2_sel ? din : core_regs[a2]);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) core_regs[i] <= '0;
            core_dout <= '0;
        end else begin
            core_dout <= core_alu;
            if (w_en) core_regs[a1] <= din_sel ? din : core_alu;
        end
    end

    // ---------------- reference model -----------------
    instr_t        prog_q[$];
    logic [DW-1:0] m_regs [8];
    logic [DW-1:0] m_result;

    // Apply the first 'upto' program words to the model register file; returns last ALU value
    function automatic logic [DW-1:0] model_exec(input int upto);
        logic [DW-1:0] v, b;
        v = '0;
        for (int i = 0; i < upto; i++) begin
            b = prog_q[i].d2_sel ? prog_q[i].din : m_regs[prog_q[i].a2];
            v = alu_f(prog_q[i].alu_sel, m_regs[prog_q[i].a1], b);
            if (prog_q[i].w_en) m_regs[prog_q[i].a1] = prog_q[i].din_sel ? prog_q[i].din : v;
        end
        return v;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.alu_sel = 2'($urandom_range(0, 3));
        t.w_en    = 1'($urandom_range(0, 1));
        t.a1      = AW'($urandom_range(0, 7));
        t.a2      = AW'($urandom_range(0, 7));
        t.din     = DW'($urandom_range(0, 255));
        t.din_sel = 1'($urandom_range(0, 1));
        t.d2_sel  = 1'($urandom_range(0, 1));
        return t;
    endfunction

    function automatic instr_t ctrl_now();
        instr_t t;
        t = {alu_sel, w_en, a1, a2, din, din_sel, d2_sel};
        return t;
    endfunction

    // ---------------- tasks -----------------
    task automatic load_word(input instr_t w);
        logic exp_rdy;
        prog_valid = 1'b1;
        prog_instr = w;
        #1;
        exp_rdy = (prog_q.size() < DEPTH);
        n_checks++;
        if (prog_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL load_ready: got %0b expected %0b", prog_ready, exp_rdy);
        end
        if (exp_rdy) prog_q.push_back(w);
        @(negedge clk);
        prog_valid = 1'b0;
    endtask

    task automatic clear_buf();
        clear = 1'b1;
        #1;
        n_checks++;
        if (prog_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready: got %0b expected 0", prog_ready);
        end
        @(negedge clk);
        clear = 1'b0;
        prog_q.delete();
        n_checks++;
        if (count !== CW'(0)) begin
            n_fail++;
            $display("FAIL clear_count: got %0d expected 0", count);
        end
    endtask

    // Start the loaded program and check every cycle of its execution.
    // stop_k >= 0 raises abort (or rst when by_rst) in the cycle after edge E+stop_k.
    task automatic run_program(input int stop_k, input bit by_rst, input bit noise, input bit with_load);
        int            n;
        int            executed;
        instr_t        exp_c;
        logic [DW-1:0] exp_res;
        n = prog_q.size();
        start = 1'b1;
        if (with_load) begin
            prog_valid = 1'b1;
            prog_instr = rand_instr();
            #1;
            n_checks++;
            if (prog_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL start_load_ready: got %0b expected 0", prog_ready);
            end
        end
        @(negedge clk);
        start      = 1'b0;
        prog_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || ctrl_now() !== instr_t'(0)) begin
            n_fail++;
            $display("FAIL run_entry: busy %0b ctrl %0h expected busy 1 ctrl 0", busy, ctrl_now());
        end
        executed = (stop_k >= 0 && stop_k < n) ? stop_k : n;
        exp_res  = model_exec(executed);
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            if (stop_k >= 0 && k == stop_k + 1) begin
                abort = 1'b0;
                rst   = 1'b0;
                n_checks++;
                if (ctrl_now() !== instr_t'(0) || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stop_state: ctrl %0h busy %0b done %0b expected all 0",
                             ctrl_now(), busy, done);
                end
                n_checks++;
                if (result !== (by_rst ? DW'(0) : m_result)) begin
                    n_fail++;
                    $display("FAIL stop_result: got %0h expected %0h", result,
                             by_rst ? DW'(0) : m_result);
                end
                n_checks++;
                if (count !== (by_rst ? CW'(0) : CW'(n))) begin
                    n_fail++;
                    $display("FAIL stop_count: got %0d expected %0d", count, by_rst ? 0 : n);
                end
                if (by_rst) begin
                    prog_q.delete();
                    m_result = '0;
                    for (int i = 0; i < 8; i++) m_regs[i] = '0;
                end
                repeat (3) begin
                    @(negedge clk);
                    n_checks++;
                    if (done !== 1'b0 || busy !== 1'b0 || ctrl_now() !== instr_t'(0)) begin
                        n_fail++;
                        $display("FAIL post_stop: done %0b busy %0b ctrl %0h expected all 0",
                                 done, busy, ctrl_now());
                    end
                end
                return;
            end
            if (k <= n) exp_c = prog_q[k-1];
            else        exp_c = '0;
            n_checks++;
            if (ctrl_now() !== exp_c) begin
                n_fail++;
                $display("FAIL ctrl k=%0d: got %0h expected %0h", k, ctrl_now(), exp_c);
            end
            n_checks++;
            if (busy !== (k <= n + 2) || done !== (k == n + 2) || count !== CW'(n)) begin
                n_fail++;
                $display("FAIL status k=%0d: busy %0b done %0b count %0d expected %0b %0b %0d",
                         k, busy, done, count, (k <= n + 2), (k == n + 2), n);
            end
            if (k == n + 2) begin
                n_checks++;
                if (result !== exp_res) begin
                    n_fail++;
                    $display("FAIL result: got %0h expected %0h", result, exp_res);
                end
                m_result = exp_res;
            end
            clear = (noise && k <= n + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stop_k >= 0 && k == stop_k) begin
                if (by_rst) rst = 1'b1;
                else        abort = 1'b1;
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_result = '0;
        prog_q.delete();
        #1;
        n_checks++;
        if (count !== CW'(0) || busy !== 1'b0 || done !== 1'b0 || result !== DW'(0) ||
            ctrl_now() !== instr_t'(0) || prog_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: count %0d busy %0b done %0b result %0h ctrl %0h ready %0b expected 0 0 0 0 0 1",
                     count, busy, done, result, ctrl_now(), prog_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || ctrl_now() !== instr_t'(0)) begin
                n_fail++;
                $display("FAIL empty_start: busy %0b done %0b ctrl %0h expected all 0",
                         busy, done, ctrl_now());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        instr_t w;
        w = '0; w.w_en = 1'b1; w.din_sel = 1'b1; w.a1 = 3'd1; w.din = 8'd5;
        load_word(w);
        w = '0; w.w_en = 1'b1; w.din_sel = 1'b1; w.a1 = 3'd2; w.din = 8'd7;
        load_word(w);
        w = '0; w.alu_sel = 2'd0; w.a1 = 3'd1; w.a2 = 3'd2;
        load_word(w);
        n_checks++;
        if (count !== CW'(3)) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected 3", count);
        end
        run_program(-1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (result !== 8'd12) begin
            n_fail++;
            $display("FAIL basic_result: got %0d expected 12", result);
        end
    endtask

    task automatic test_full();
        logic exp_rdy;
        clear_buf();
        prog_valid = 1'b1;
        for (int j = 0; j < DEPTH + 1; j++) begin
            prog_instr = rand_instr();
            #1;
            exp_rdy = (prog_q.size() < DEPTH);
            n_checks++;
            if (prog_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL full_ready j=%0d: got %0b expected %0b", j, prog_ready, exp_rdy);
            end
            if (exp_rdy) prog_q.push_back(prog_instr);
            @(negedge clk);
        end
        prog_valid = 1'b0;
        n_checks++;
        if (count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_count: got %0d expected %0d", count, DEPTH);
        end
        run_program(-1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        clear_buf();
        repeat (5) load_word(rand_instr());
        run_program(2, 1'b0, 1'b0, 1'b0);
        run_program(-1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_with_load();
        run_program(-1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        repeat (6) begin
            clear_buf();
            n = $urandom_range(1, DEPTH);
            repeat (n) load_word(rand_instr());
            run_program(-1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_rst_run();
        clear_buf();
        repeat (5) load_word(rand_instr());
        run_program(2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_empty_start();
        test_basic();
        test_full();
        test_abort();
        test_start_with_load();
        test_random();
        test_rst_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
